// File: rtl/inst_fetch.sv
// inst_fetch: instruction fetch stage feeding the decoder.
// Holds the fetch PC, issues one 16-bit word request at a time over a
// req/ack handshake and buffers returned words in a prefetch FIFO.
// Optional feature macro: IFETCH_PERF_CNT_EN adds the O_fetch_cnt
// delivered-instruction counter.
//
// Handshakes:
//   memory : O_mem_req/O_mem_addr are registered and held stable until a
//            cycle with I_mem_ack=1, which completes the transfer and
//            carries I_mem_data in that same cycle.
//   decoder: a head transfer happens on every rising edge where
//            O_inst_valid && I_inst_ready; O_inst/O_pc stay stable while
//            valid and not ready.
module inst_fetch #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        I_clk,
    input  logic        I_rst,
    input  logic        I_en,
    output logic        O_mem_req,
    output logic [15:0] O_mem_addr,
    input  logic        I_mem_ack,
    input  logic [15:0] I_mem_data,
    output logic [15:0] O_inst,
    output logic [15:0] O_pc,
    output logic        O_inst_valid,
    input  logic        I_inst_ready,
    input  logic        I_branch,
    input  logic [15:0] I_branch_tgt,
`ifdef IFETCH_PERF_CNT_EN
    output logic [15:0] O_fetch_cnt,
`endif
    output logic [1:0]  O_dbg_state
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    // IDLE: nothing outstanding; REQ: request outstanding, data wanted;
    // FLUSH: request outstanding, data to be dropped after a redirect.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic [15:0]        fetch_pc;
    logic [15:0]        fetch_pc_nx;
    logic               req_nx;
    logic [15:0]        addr_nx;
    logic               push;
    logic               pop;

    logic [15:0]        fifo_inst [FIFO_DEPTH];
    logic [15:0]        fifo_pc   [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_plus1;

    assign O_inst_valid = (count != '0);
    assign O_inst       = fifo_inst[rd_ptr];
    assign O_pc         = fifo_pc[rd_ptr];
    assign O_dbg_state  = state;
    assign pop          = O_inst_valid && I_inst_ready;
    assign count_plus1  = count + CNT_W'(1);

    // Next-state, next request and fetch PC; a redirect always wins over the PC increment.
    always_comb begin
        state_nx    = state;
        fetch_pc_nx = fetch_pc;
        req_nx      = O_mem_req;
        addr_nx     = O_mem_addr;
        push        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (I_branch) begin
                    fetch_pc_nx = I_branch_tgt;
                end else if (I_en && (count < DEPTH_C)) begin
                    state_nx = ST_REQ;
                    req_nx   = 1'b1;
                    addr_nx  = fetch_pc;
                end
            end
            ST_REQ: begin
                if (I_mem_ack) begin
                    if (I_branch) begin
                        // Returned word belongs to the old path: drop it.
                        fetch_pc_nx = I_branch_tgt;
                        if (I_en) begin
                            addr_nx = I_branch_tgt;
                        end else begin
                            state_nx = ST_IDLE;
                            req_nx   = 1'b0;
                        end
                    end else begin
                        push        = 1'b1;
                        fetch_pc_nx = O_mem_addr + 16'd1;
                        if (I_en && (count_plus1 < DEPTH_C)) begin
                            addr_nx = O_mem_addr + 16'd1;
                        end else begin
                            state_nx = ST_IDLE;
                            req_nx   = 1'b0;
                        end
                    end
                end else if (I_branch) begin
                    // Request must still complete; remember to discard it.
                    fetch_pc_nx = I_branch_tgt;
                    state_nx    = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (I_branch) begin
                    fetch_pc_nx = I_branch_tgt;
                end
                if (I_mem_ack) begin
                    state_nx = ST_IDLE;
                    req_nx   = 1'b0;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                req_nx   = 1'b0;
            end
        endcase
    end

    // FSM state, fetch PC and registered memory request.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state      <= ST_IDLE;
            fetch_pc   <= RESET_PC;
            O_mem_req  <= 1'b0;
            O_mem_addr <= 16'h0000;
        end else begin
            state      <= state_nx;
            fetch_pc   <= fetch_pc_nx;
            O_mem_req  <= req_nx;
            O_mem_addr <= addr_nx;
        end
    end

    // Prefetch FIFO: push returned words, pop on decoder transfer, clear on redirect.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_inst[i] <= 16'h0000;
                fifo_pc[i]   <= 16'h0000;
            end
        end else if (I_branch) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                fifo_inst[wr_ptr] <= I_mem_data;
                fifo_pc[wr_ptr]   <= O_mem_addr;
                wr_ptr            <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

`ifdef IFETCH_PERF_CNT_EN
    // Delivered-instruction counter; only reset clears it, a redirect does not.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            O_fetch_cnt <= 16'h0000;
        end else if (pop) begin
            O_fetch_cnt <= O_fetch_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed and randomized checks of inst_fetch against a
// queue-based reference model of the fetch stage.
module tb_inst_fetch;

    localparam logic [15:0] RST_PC = 16'h0010;
    localparam int          DEPTH  = 4;

    // clock / reset block
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_data = 16'h0000;
    logic        inst_ready = 1'b0;
    logic        branch = 1'b0;
    logic [15:0] branch_tgt = 16'h0000;

    logic        mem_req;
    logic [15:0] mem_addr;
    logic [15:0] inst;
    logic [15:0] pc;
    logic        inst_valid;
    logic [1:0]  dbg_state;
`ifdef IFETCH_PERF_CNT_EN
    logic [15:0] fetch_cnt;
`endif

    inst_fetch #(
        .RESET_PC   (RST_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .I_clk        (clk),
        .I_rst        (rst),
        .I_en         (en),
        .O_mem_req    (mem_req),
        .O_mem_addr   (mem_addr),
        .I_mem_ack    (mem_ack),
        .I_mem_data   (mem_data),
        .O_inst       (inst),
        .O_pc         (pc),
        .O_inst_valid (inst_valid),
        .I_inst_ready (inst_ready),
        .I_branch     (branch),
        .I_branch_tgt (branch_tgt),
`ifdef IFETCH_PERF_CNT_EN
        .O_fetch_cnt  (fetch_cnt),
`endif
        .O_dbg_state  (dbg_state)
    );

    int checks = 0;
    int errors = 0;

    // reference model: scoreboard queue of {inst, pc} plus request bookkeeping
    logic [31:0] exp_q[$];
    logic [15:0] m_fetch_pc = RST_PC;
    logic        m_req = 1'b0;
    logic [15:0] m_addr = 16'h0000;
    logic        m_discard = 1'b0;
    logic [15:0] m_cnt = 16'h0000;

    // memory contents: a fixed scramble of the word address
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        logic [15:0] p;
        p = a * 16'h9E37;
        return p ^ 16'h5A5A;
    endfunction

    task automatic model_edge();
        int   pre;
        logic was_discard;
        if (rst) begin
            exp_q.delete();
            m_fetch_pc = RST_PC;
            m_req      = 1'b0;
            m_addr     = 16'h0000;
            m_discard  = 1'b0;
            m_cnt      = 16'h0000;
            return;
        end
        pre = exp_q.size();
        if (pre > 0 && inst_ready) begin
            exp_q.delete(0);
            m_cnt = m_cnt + 16'd1;
        end
        if (branch) begin
            exp_q.delete();
            m_fetch_pc = branch_tgt;
        end
        if (m_req) begin
            if (mem_ack) begin
                was_discard = m_discard;
                m_discard   = 1'b0;
                if (!was_discard && !branch) begin
                    exp_q.push_back({mem_word(m_addr), m_addr});
                    m_fetch_pc = m_addr + 16'd1;
                end
                if (!was_discard && en && (branch || (pre + 1 < DEPTH)))
                    m_addr = m_fetch_pc;
                else
                    m_req = 1'b0;
            end else if (branch) begin
                m_discard = 1'b1;
            end
        end else if (!branch && en && pre < DEPTH) begin
            m_req  = 1'b1;
            m_addr = m_fetch_pc;
        end
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic [31:0] head;
        check("mem_req", {15'd0, mem_req}, {15'd0, m_req});
        check("mem_addr", mem_addr, m_addr);
        check("inst_valid", {15'd0, inst_valid}, {15'd0, (exp_q.size() > 0)});
        if (exp_q.size() > 0) begin
            head = exp_q[0];
            check("inst", inst, head[31:16]);
            check("pc", pc, head[15:0]);
        end
`ifdef IFETCH_PERF_CNT_EN
        check("fetch_cnt", fetch_cnt, m_cnt);
`endif
    endtask

    // driver: apply inputs, advance one edge, update model, check on falling edge
    task automatic cycle(input logic r, input logic e, input logic a, input logic rd,
                         input logic b, input logic [15:0] t);
        rst        = r;
        en         = e;
        mem_ack    = a;
        inst_ready = rd;
        branch     = b;
        branch_tgt = t;
        mem_data   = mem_word(m_addr);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        // reset state
        cycle(1, 0, 0, 0, 0, 16'h0);
        cycle(1, 1, 1, 1, 0, 16'h0);
        check("rst_inst", inst, 16'h0000);
        check("rst_pc", pc, 16'h0000);

        // zero-wait memory, decoder always ready: 0x10, 0x11, 0x12 ...
        for (int i = 0; i < 6; i++) cycle(0, 1, 1, 1, 0, 16'h0);

        // decoder stalled: FIFO fills, request stops, then drains in order
        for (int i = 0; i < 8; i++) cycle(0, 1, 1, 0, 0, 16'h0);
        check("full_req_low", {15'd0, mem_req}, 16'h0000);
        check("full_valid", {15'd0, inst_valid}, 16'h0001);
        for (int i = 0; i < 8; i++) cycle(0, 1, 1, 1, 0, 16'h0);

        // slow memory: 3 wait cycles, enable dropped mid-wait
        cycle(0, 1, 0, 1, 0, 16'h0);
        cycle(0, 1, 0, 1, 0, 16'h0);
        cycle(0, 0, 0, 1, 0, 16'h0);
        cycle(0, 0, 1, 1, 0, 16'h0);
        cycle(0, 0, 0, 1, 0, 16'h0);
        cycle(0, 0, 0, 1, 0, 16'h0);

        // redirect while a request at 0x0005 is waiting
        cycle(0, 0, 0, 1, 1, 16'h0005);
        cycle(0, 1, 0, 1, 0, 16'h0);
        cycle(0, 1, 0, 1, 0, 16'h0);
        check("wait_addr_5", mem_addr, 16'h0005);
        cycle(0, 1, 0, 1, 1, 16'h0100);
        cycle(0, 1, 0, 1, 0, 16'h0);
        cycle(0, 1, 1, 1, 0, 16'h0);
        for (int i = 0; i < 4; i++) cycle(0, 1, 1, 1, 0, 16'h0);

        // address wrap at 0xFFFF
        cycle(0, 1, 1, 1, 1, 16'hFFFE);
        for (int i = 0; i < 5; i++) cycle(0, 1, 1, 1, 0, 16'h0);

        // reset during an outstanding request
        cycle(0, 1, 0, 0, 0, 16'h0);
        cycle(1, 1, 0, 0, 0, 16'h0);
        check("rst_mid_req", {15'd0, mem_req}, 16'h0000);
        check("rst_mid_valid", {15'd0, inst_valid}, 16'h0000);
        for (int i = 0; i < 4; i++) cycle(0, 1, 1, 1, 0, 16'h0);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            logic        r, e, a, rd, b;
            logic [15:0] t;
            r  = ($urandom_range(0, 199) == 0);
            e  = ($urandom_range(0, 9) != 0);
            a  = ($urandom_range(0, 1) == 1);
            rd = ($urandom_range(0, 9) < 6);
            b  = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 3) == 0)
                t = 16'hFFFC + 16'($urandom_range(0, 3));
            else
                t = 16'($urandom_range(0, 65535));
            cycle(r, e, a, rd, b, t);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage that sits directly upstream of the instruction decoder. Holds the program counter, issues 16-bit word fetches to instruction memory over a req/ack handshake, and buffers returned instructions in a small prefetch FIFO. Presents instruction and PC to the decoder with a valid/ready handshake, and redirects on branch with a flush.

## Interface
- RESET_PC, 16'h0000: PC loaded on reset.
- FIFO_DEPTH, 4: prefetch entries; power of two, 2..16.
- I_clk  in  1  clock, all state updates on rising edge.
- I_rst  in  1  synchronous, active-high reset.
- I_en  in  1  fetch enable; 0 blocks new memory requests.
- O_mem_req  out  1  memory request, registered.
- O_mem_addr  out  16  word address of request, registered.
- I_mem_ack  in  1  request accepted; data valid this cycle.
- I_mem_data  in  16  instruction word, sampled when I_mem_ack=1.
- O_inst  out  16  FIFO head instruction, to decoder I_inst.
- O_pc  out  16  address of O_inst.
- O_inst_valid  out  1  FIFO non-empty.
- I_inst_ready  in  1  decoder accepts head this cycle.
- I_branch  in  1  single-cycle redirect pulse.
- I_branch_tgt  in  16  redirect target.
- O_fetch_cnt  out  16  instructions delivered (only with IFETCH_PERF_CNT_EN).

## Operation
- FSM states: IDLE (no request outstanding), REQ (O_mem_req=1, awaiting ack), FLUSH (request outstanding whose data must be discarded).
- Reset: state IDLE; fetch PC = RESET_PC; FIFO empty; O_mem_req=0, O_mem_addr=0, O_inst=0, O_pc=0, O_inst_valid=0, O_fetch_cnt=0.
- IDLE -> REQ when I_en=1 and count < FIFO_DEPTH: O_mem_req=1, O_mem_addr=fetch PC.
- REQ: O_mem_req and O_mem_addr held stable until I_mem_ack=1, regardless of I_en. On ack: {I_mem_data, O_mem_addr} pushed, fetch PC += 1 (mod 2^16, 16'hFFFF wraps to 16'h0000). If I_en=1 and post-push count < FIFO_DEPTH, reissue immediately at new PC (stay REQ). Otherwise go to IDLE.
- At most one request outstanding; a push therefore never overflows the FIFO.
- Pop when O_inst_valid && I_inst_ready. Push and pop in the same cycle leave count unchanged.
- I_branch=1: FIFO cleared and fetch PC = I_branch_tgt. Any head transfer (valid && ready) in that cycle counts as delivered.
  - In IDLE: next state IDLE; the request for the target issues under the normal IDLE rule.
  - In REQ with no ack: go to FLUSH. Old request is held until ack, then its data is dropped.
  - In REQ with ack the same cycle: ack data is dropped and the next request uses I_branch_tgt.
- FLUSH: on ack, data is dropped and the FSM goes to IDLE. A further I_branch in FLUSH only updates fetch PC.
- I_rst overrides everything, including mid-handshake. O_mem_req drops the next cycle and the outstanding request is abandoned.

## Timing
- Ack sampled at edge N -> O_inst_valid=1 from cycle N+1 (1-cycle latency).
- With a zero-wait memory (ack tied high), throughput is one instruction per cycle after a 1-cycle request startup.
- First O_mem_req rises the cycle after the edge on which I_rst=0 and I_en=1 are sampled.
- Branch sampled at edge N -> O_inst_valid=0 in cycle N+1. The earliest target request is O_mem_req in N+1 (when no flush is pending).
- O_inst/O_pc change only on pop, push-to-empty, or flush.

## Configuration
- IFETCH_PERF_CNT_EN defined: O_fetch_cnt exists. It increments by 1 per pop, wraps at 16'hFFFF, and is cleared by reset only (not by branch).
- Not defined: port and counter are absent. All other behaviour is identical.

## Test plan
- Reset with RESET_PC=16'h0010, I_en=1, ack tied high, ready=1 -> O_mem_addr 0x0010, 0x0011, 0x0012 on consecutive cycles; O_pc follows one cycle later; O_inst equals the memory contents.
- ready=0, ack tied high, depth 4 -> exactly 4 pushes, then O_mem_req=0 and O_inst_valid stays 1. Raising ready drains 4 instructions in order, with refill resuming.
- Ack delayed 3 cycles -> O_mem_addr stable during the wait. Drop I_en mid-wait -> req held until ack, then deasserts.
- I_branch to 16'h0100 while REQ waits on addr 0x0005 -> 0x0005 data discarded, FIFO empty. Next request is 0x0100, and the first delivered O_pc=0x0100.
- PC at 16'hFFFF, ack tied high -> next O_mem_addr 16'h0000. With IFETCH_PERF_CNT_EN, O_fetch_cnt equals the pop count and is unchanged by branch.
- I_rst asserted during an outstanding request -> the next cycle has O_mem_req=0, O_inst_valid=0, fetch restarts at RESET_PC, and O_fetch_cnt=0.
